store_retire_buffer: RTL and testbench

- Post-retirement store buffer that sits directly downstream of the retire stage.
- Captures each retired store (command, size, address, data) in program order and drains it to data memory when the bus is free.
- Loads issued by the LSQ have bus priority; stores wait while a load is requesting the bus.
- Raises `full` to stall retirement and `empty` so the pipeline only reports halt once all committed stores have reached memory.

---
 rtl/store_retire_buffer_if.sv | 67 ++++++
 rtl/store_retire_buffer.sv | 109 ++++++++++
 tb/tb_store_retire_buffer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/store_retire_buffer_if.sv
// Store retire buffer bus bundle: retire-side push, LSQ/memory handshake, Dmem drive.
// Optional forwarding ports are present when STORE_FWD_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

package store_retire_buffer_pkg;
  localparam int unsigned MEM_SIZE_W = 2;
  localparam int unsigned CMD_W      = 2;
  localparam int unsigned RESP_W     = 4;

  typedef logic [MEM_SIZE_W-1:0] mem_size_t;
  typedef logic [CMD_W-1:0]      bus_cmd_t;

  localparam bus_cmd_t BUS_NONE  = 2'd0;
  localparam bus_cmd_t BUS_LOAD  = 2'd1;
  localparam bus_cmd_t BUS_STORE = 2'd2;

  localparam mem_size_t BYTE   = 2'd0;
  localparam mem_size_t HALF   = 2'd1;
  localparam mem_size_t WORD   = 2'd2;
  localparam mem_size_t DOUBLE = 2'd3;
endpackage

interface store_retire_buffer_if;
  import store_retire_buffer_pkg::*;

  bus_cmd_t                     st_command;
  mem_size_t                    st_size;
  logic [`XLEN-1:0]             st_addr;
  logic [`XLEN-1:0]             st_data;
  logic                         load_req;
  logic [RESP_W-1:0]            mem_response;
  bus_cmd_t                     Dmem_command;
  mem_size_t                    Dmem_size;
  logic [`XLEN-1:0]             Dmem_addr;
  logic [`XLEN-1:0]             Dmem_data;
  logic                         full;
  logic                         empty;
  logic                         overflow;
`ifdef STORE_FWD_EN
  logic [`XLEN-1:0]             fwd_addr;
  mem_size_t                    fwd_size;
  logic                         fwd_hit;
  logic [`XLEN-1:0]             fwd_data;
`endif

  // Pipeline / memory side: drives pushes and bus status, observes the drain.
  modport master (
    output st_command, st_size, st_addr, st_data, load_req, mem_response,
`ifdef STORE_FWD_EN
    output fwd_addr, fwd_size,
    input  fwd_hit, fwd_data,
`endif
    input  Dmem_command, Dmem_size, Dmem_addr, Dmem_data, full, empty, overflow
  );

  // Buffer side.
  modport slave (
    input  st_command, st_size, st_addr, st_data, load_req, mem_response,
`ifdef STORE_FWD_EN
    input  fwd_addr, fwd_size,
    output fwd_hit, fwd_data,
`endif
    output Dmem_command, Dmem_size, Dmem_addr, Dmem_data, full, empty, overflow
  );
endinterface

// File: rtl/store_retire_buffer.sv
// Post-retirement store buffer: in-order FIFO of committed stores drained to
// Dmem whenever the LSQ is not using the bus. Optional store-to-load
// forwarding CAM is compiled in with STORE_FWD_EN.
module store_retire_buffer
  import store_retire_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  store_retire_buffer_if.slave bus
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SEND, YIELD} state_e;

  state_e           state_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q;

  mem_size_t        size_q [DEPTH];
  logic [`XLEN-1:0] addr_q [DEPTH];
  logic [`XLEN-1:0] data_q [DEPTH];

  logic full_c, empty_c, push_c, drop_c, drive_c, pop_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = (bus.st_command == BUS_STORE) && !full_c;
  assign drop_c  = (bus.st_command == BUS_STORE) && full_c;
  // Head is driven only in SEND with the bus free; YIELD always idles the bus
  // for its cycles, so resuming after a load costs one bubble.
  assign drive_c = (state_q == SEND) && !bus.load_req;
  assign pop_c   = drive_c && (bus.mem_response != '0);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, count, sticky overflow and drain FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      count_q <= count_d;
      if (push_c) tail_q <= PTR_W'(tail_q + PTR_W'(1));
      if (pop_c)  head_q <= PTR_W'(head_q + PTR_W'(1));
      if (drop_c) overflow_q <= 1'b1;
      case (state_q)
        IDLE:    if (push_c) state_q <= SEND;
        SEND: begin
          if (bus.load_req)                  state_q <= YIELD;
          else if (pop_c && count_d == '0)   state_q <= IDLE;
        end
        YIELD:   if (!bus.load_req) state_q <= SEND;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Entry payload storage; contents are don't-care until pushed.
  always_ff @(posedge clock) begin
    if (push_c) begin
      size_q[tail_q] <= bus.st_size;
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
    end
  end

  assign bus.Dmem_command = drive_c ? BUS_STORE : BUS_NONE;
  assign bus.Dmem_size    = drive_c ? size_q[head_q] : '0;
  assign bus.Dmem_addr    = drive_c ? addr_q[head_q] : '0;
  assign bus.Dmem_data    = drive_c ? data_q[head_q] : '0;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.overflow     = overflow_q;

`ifdef STORE_FWD_EN
  // Oldest-to-youngest scan so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    idx          = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = PTR_W'(head_q + PTR_W'(k));
      if ((CNT_W'(k) < count_q) && (addr_q[idx] == bus.fwd_addr) &&
          (size_q[idx] == bus.fwd_size)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = data_q[idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_retire_buffer.sv
// Scoreboarded bench for store_retire_buffer: directed pushes queue the
// expected Dmem writes; a negedge monitor checks every accepted store.
module tb_store_retire_buffer;
  import store_retire_buffer_pkg::*;

  typedef struct packed {
    mem_size_t        size;
    logic [`XLEN-1:0] addr;
    logic [`XLEN-1:0] data;
  } wr_t;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  wr_t  sb [$];

  store_retire_buffer_if bus ();

  store_retire_buffer #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [`XLEN-1:0] a, input logic [`XLEN-1:0] d, input logic expect_write);
    wr_t w;
    bus.st_command = BUS_STORE;
    bus.st_size    = WORD;
    bus.st_addr    = a;
    bus.st_data    = d;
    w.size = WORD;
    w.addr = a;
    w.data = d;
    if (expect_write) sb.push_back(w);
  endtask

  task automatic no_push();
    bus.st_command = BUS_NONE;
    bus.st_addr    = '0;
    bus.st_data    = '0;
  endtask

  // Monitor: every accepted store must be the oldest expected one.
  always @(negedge clock) begin
    if (reset && bus.Dmem_command == BUS_STORE && bus.mem_response != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h expected none", bus.Dmem_addr);
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("wr_addr", 64'(bus.Dmem_addr), 64'(w.addr));
        chk("wr_data", 64'(bus.Dmem_data), 64'(w.data));
        chk("wr_size", 64'(bus.Dmem_size), 64'(w.size));
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.load_req     = 1'b0;
    bus.mem_response = '0;
    bus.st_size      = WORD;
`ifdef STORE_FWD_EN
    bus.fwd_addr = '0;
    bus.fwd_size = WORD;
`endif
    no_push();

    // Reset, then idle with no pushes.
    #1;
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_cmd", 64'(bus.Dmem_command), 64'(BUS_NONE));
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_empty", 64'(bus.empty), 64'd1);
      chk("idle_cmd", 64'(bus.Dmem_command), 64'(BUS_NONE));
      chk("idle_ovf", 64'(bus.overflow), 64'd0);
    end

    // Single store: no same-cycle bypass, drives next cycle, accepted at once.
    push(32'h100, 32'hDEADBEEF, 1'b1);
    bus.mem_response = 4'd1;
    #1;
    chk("single_nobypass", 64'(bus.Dmem_command), 64'(BUS_NONE));
    tick();
    no_push();
    #1;
    chk("single_cmd", 64'(bus.Dmem_command), 64'(BUS_STORE));
    chk("single_addr", 64'(bus.Dmem_addr), 64'h100);
    tick();
    chk("single_empty", 64'(bus.empty), 64'd1);
    chk("single_idle_cmd", 64'(bus.Dmem_command), 64'(BUS_NONE));

    // Fill to full with memory stalled, then overflow push.
    bus.mem_response = '0;
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b1);
      tick();
    end
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_ovf_pre", 64'(bus.overflow), 64'd0);
    push(32'h110, 32'hBAD, 1'b0);
    tick();
    no_push();
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    chk("ovf_still_full", 64'(bus.full), 64'd1);
    bus.mem_response = 4'd3;
    for (int i = 0; i < 4; i++) tick();
    chk("fill_drained", 64'(bus.empty), 64'd1);
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);

    // Load priority: two stores buffered, load holds the bus for 3 cycles.
    bus.mem_response = '0;
    push(32'h200, 32'h2222_0000, 1'b1);
    tick();
    push(32'h204, 32'h2222_0004, 1'b1);
    tick();
    no_push();
    bus.load_req     = 1'b1;
    bus.mem_response = 4'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("load_yield_cmd", 64'(bus.Dmem_command), 64'(BUS_NONE));
      tick();
    end
    bus.load_req = 1'b0;
    for (int i = 0; i < 10 && !bus.empty; i++) tick();
    chk("load_drained", 64'(bus.empty), 64'd1);

    // Wrap-around: push every cycle while memory accepts every cycle.
    bus.mem_response = '0;
    push(32'h300, 32'h3000, 1'b1);
    tick();
    push(32'h304, 32'h3004, 1'b1);
    tick();
    bus.mem_response = 4'd1;
    for (int i = 0; i < 12; i++) begin
      push(32'h308 + 32'(4 * i), 32'h3008 + 32'(4 * i), 1'b1);
      tick();
      chk("wrap_not_empty", 64'(bus.empty), 64'd0);
      chk("wrap_not_full", 64'(bus.full), 64'd0);
    end
    no_push();
    for (int i = 0; i < 10 && !bus.empty; i++) tick();
    chk("wrap_drained", 64'(bus.empty), 64'd1);
    chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // Async reset mid-drain with 3 entries: entries dropped, nothing retried.
    bus.mem_response = '0;
    for (int i = 0; i < 3; i++) begin
      push(32'h400 + 32'(4 * i), 32'h4000 + 32'(i), 1'b0);
      tick();
    end
    no_push();
    #1;
    chk("pre_rst_cmd", 64'(bus.Dmem_command), 64'(BUS_STORE));
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_cmd", 64'(bus.Dmem_command), 64'(BUS_NONE));
    chk("mid_rst_empty", 64'(bus.empty), 64'd1);
    chk("mid_rst_ovf", 64'(bus.overflow), 64'd0);
    tick();
    #2;
    reset = 1'b1;
    bus.mem_response = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_cmd", 64'(bus.Dmem_command), 64'(BUS_NONE));
      chk("post_rst_empty", 64'(bus.empty), 64'd1);
    end
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
